// File: rtl/square_period_meter_if.sv
// Measurement bus of the square-wave period meter: raw square wave in, averaged
// period / frequency results and loss-of-signal status out.
interface square_period_meter_if;
    logic        pulse_in;
    logic        freq_valid;
    logic [31:0] period_cnt_reg;
    logic [31:0] freq_out;
    logic        signal_lost;

    modport master (
        input  pulse_in,
        output freq_valid, period_cnt_reg, freq_out, signal_lost
    );

    modport slave (
        output pulse_in,
        input  freq_valid, period_cnt_reg, freq_out, signal_lost
    );
endinterface

// File: rtl/square_period_meter.sv
// Square-wave period meter: synchronise and debounce the input, average 2^AVG_LOG2
// periods between rising edges, then divide CLK_FREQ_HZ by the average for Hz.
module square_period_meter #(
    parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
    parameter int unsigned DEBOUNCE_TIME = 100,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned MIN_PERIOD    = 200,
    parameter int unsigned MAX_PERIOD    = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    square_period_meter_if.master bus
);
    localparam int unsigned WINDOW = 1 << AVG_LOG2;
    localparam int          ACC_W  = 32 + AVG_LOG2;
    localparam int          RND_W  = ACC_W + 1;
    localparam int          N_W    = AVG_LOG2 + 1;
    localparam logic [31:0] MAXP   = 32'(MAX_PERIOD);
    localparam logic [31:0] MINP   = 32'(MIN_PERIOD);
    localparam logic [N_W-1:0] N_LAST = N_W'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} meas_state_t;
    typedef enum logic [1:0] {DIV_IDLE, DIV_LOAD, DIV_RUN, DIV_DONE} div_state_t;

    logic        sync1, sync2, stable, stable_q, edge_evt;
    logic [7:0]  db_cnt;
    logic [31:0] period_cnt;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            edge_evt <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= bus.pulse_in;
            sync2    <= sync1;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == 8'(DEBOUNCE_TIME - 1)) begin
                stable <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
            stable_q <= stable;
            edge_evt <= stable & ~stable_q;
        end
    end

    // Cycles since the last edge event; the edge cycle itself reloads to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    period_cnt <= '0;
        else if (edge_evt)           period_cnt <= 32'd1;
        else if (period_cnt != MAXP) period_cnt <= period_cnt + 32'd1;
    end

    meas_state_t      meas_state, meas_next;
    div_state_t       div_state, div_next;
    logic [ACC_W-1:0] acc, acc_sum;
    logic [N_W-1:0]   acc_n;
    logic [RND_W-1:0] rounded;
    logic [31:0]      avg_next, avg_snap;
    logic             sample_ok, take_sample, window_close, timeout;

    assign sample_ok = (period_cnt >= MINP);
    assign acc_sum   = acc + ACC_W'(period_cnt);
    assign rounded   = {1'b0, acc_sum} + RND_W'(WINDOW / 2);
    assign avg_next  = 32'(rounded >> AVG_LOG2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meas_state <= IDLE;
            div_state  <= DIV_IDLE;
        end else begin
            meas_state <= meas_next;
            div_state  <= div_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        meas_next    = meas_state;
        take_sample  = 1'b0;
        window_close = 1'b0;
        timeout      = 1'b0;
        unique case (meas_state)
            IDLE: if (edge_evt) meas_next = ARM;
            ARM, MEASURE: begin
                if (edge_evt) begin
                    meas_next    = MEASURE;
                    take_sample  = sample_ok;
                    window_close = sample_ok && (acc_n == N_LAST);
                end else if (period_cnt == MAXP) begin
                    meas_next = IDLE;
                    timeout   = 1'b1;
                end
            end
            default: meas_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            acc_n <= '0;
        end else if (timeout || window_close) begin
            acc   <= '0;
            acc_n <= '0;
        end else if (take_sample) begin
            acc   <= acc_sum;
            acc_n <= acc_n + N_W'(1);
        end
    end

    logic [31:0] div_rem, div_quo;
    logic [4:0]  div_cnt;
    logic [32:0] rem_shift;
    logic [31:0] rem_next;
    logic        q_bit, div_lost;

    // Restoring divide: one quotient bit per cycle, dividend shifted in from div_quo.
    assign rem_shift = {div_rem, div_quo[31]};
    assign q_bit     = (rem_shift >= {1'b0, avg_snap});
    assign rem_next  = q_bit ? 32'(rem_shift - {1'b0, avg_snap}) : 32'(rem_shift);

    always_comb begin
        div_next = div_state;
        unique case (div_state)
            DIV_IDLE: if (window_close) div_next = DIV_LOAD;
            DIV_LOAD: div_next = DIV_RUN;
            DIV_RUN:  if (div_cnt == 5'd31) div_next = DIV_DONE;
            DIV_DONE: div_next = window_close ? DIV_LOAD : DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avg_snap <= '0;
            div_rem  <= '0;
            div_quo  <= '0;
            div_cnt  <= '0;
            div_lost <= 1'b0;
        end else begin
            if (window_close) avg_snap <= avg_next;
            if (div_state == DIV_LOAD) begin
                div_rem <= '0;
                div_quo <= 32'(CLK_FREQ_HZ);
                div_cnt <= '0;
            end else if (div_state == DIV_RUN) begin
                div_rem <= rem_next;
                div_quo <= {div_quo[30:0], q_bit};
                div_cnt <= div_cnt + 5'd1;
            end
            // A timeout during a divide lets the result publish but keeps signal_lost set.
            if (window_close) div_lost <= 1'b0;
            else if (timeout) div_lost <= 1'b1;
        end
    end

    logic        freq_valid_r, signal_lost_r;
    logic [31:0] period_r, freq_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq_valid_r  <= 1'b0;
            period_r      <= '0;
            freq_r        <= '0;
            signal_lost_r <= 1'b1;
        end else begin
            freq_valid_r <= (div_state == DIV_DONE);
            if (div_state == DIV_DONE) begin
                period_r <= avg_snap;
                freq_r   <= div_quo;
            end
            if (timeout)                                  signal_lost_r <= 1'b1;
            else if (div_state == DIV_DONE && !div_lost)  signal_lost_r <= 1'b0;
        end
    end

    assign bus.freq_valid     = freq_valid_r;
    assign bus.period_cnt_reg = period_r;
    assign bus.freq_out       = freq_r;
    assign bus.signal_lost    = signal_lost_r;
endmodule

// File: tb/tb_square_period_meter.sv
// Directed and randomised bench for square_period_meter; expected results come from
// an arithmetic model of rising-edge periods, windows and the Hz division.
module tb_square_period_meter;
    localparam int unsigned CLK_HZ   = 100_000_000;
    localparam int unsigned DB       = 100;
    localparam int unsigned AVG_LOG2 = 3;
    localparam int unsigned MINP     = 500;
    localparam int unsigned MAXP     = 5000;
    localparam int unsigned WIN      = 1 << AVG_LOG2;
    localparam int unsigned LAT      = DB + 3 + 35;

    typedef struct {
        int unsigned cyc;
        int unsigned period;
        int unsigned freq;
        logic        lost;
    } result_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned last_rise = 0;
    int unsigned target = 0;

    result_t obs_q[$];
    result_t exp_q[$];
    result_t mon_r;

    bit              m_active;
    int unsigned     m_prev;
    longint unsigned m_sum;
    int unsigned     m_n;

    square_period_meter_if bus();

    square_period_meter #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .DEBOUNCE_TIME(DB),
        .AVG_LOG2     (AVG_LOG2),
        .MIN_PERIOD   (MINP),
        .MAX_PERIOD   (MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.freq_valid === 1'b1) begin
            mon_r.cyc    = cyc;
            mon_r.period = bus.period_cnt_reg;
            mon_r.freq   = bus.freq_out;
            mon_r.lost   = bus.signal_lost;
            obs_q.push_back(mon_r);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_sum    = 0;
        m_n      = 0;
    endtask

    // One rising edge of the applied wave at bench cycle k.
    task automatic model_edge(input int unsigned k);
        int unsigned p;
        result_t r;
        if (!m_active) begin
            m_active = 1'b1;
            m_prev   = k;
            return;
        end
        p      = k - m_prev;
        m_prev = k;
        if (p >= MINP && p <= MAXP) begin
            m_sum += p;
            m_n++;
            if (m_n == WIN) begin
                r.cyc    = k + LAT;
                r.period = int'((m_sum + WIN / 2) / WIN);
                r.freq   = CLK_HZ / r.period;
                r.lost   = 1'b0;
                exp_q.push_back(r);
                m_sum = 0;
                m_n   = 0;
            end
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_cyc"},    obs_q[i].cyc,    exp_q[i].cyc);
            check({tag, "_period"}, obs_q[i].period, exp_q[i].period);
            check({tag, "_freq"},   obs_q[i].freq,   exp_q[i].freq);
            check({tag, "_lost"},   obs_q[i].lost,   exp_q[i].lost);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wave(input int unsigned hi, input int unsigned lo);
        bus.pulse_in = 1'b1;
        last_rise = cyc;
        model_edge(cyc);
        repeat (hi) @(negedge clk);
        bus.pulse_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Same period as wave(), with a 20-cycle glitch in the middle of each level.
    task automatic glitch_wave(input int unsigned hi, input int unsigned lo);
        bus.pulse_in = 1'b1;
        last_rise = cyc;
        model_edge(cyc);
        repeat (hi / 2) @(negedge clk);
        bus.pulse_in = 1'b0;
        repeat (20) @(negedge clk);
        bus.pulse_in = 1'b1;
        repeat (hi - hi / 2 - 20) @(negedge clk);
        bus.pulse_in = 1'b0;
        repeat (lo / 2) @(negedge clk);
        bus.pulse_in = 1'b1;
        repeat (20) @(negedge clk);
        bus.pulse_in = 1'b0;
        repeat (lo - lo / 2 - 20) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"},  bus.freq_valid,     1'b0);
        check({tag, "_period"}, bus.period_cnt_reg, 32'd0);
        check({tag, "_freq"},   bus.freq_out,       32'd0);
        check({tag, "_lost"},   bus.signal_lost,    1'b1);
    endtask

    initial begin
        bus.pulse_in = 1'b0;
        rst = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 1000-cycle wave: first result after the 9th edge.
        repeat (8) wave(500, 500);
        check("pre_lock_results", obs_q.size(), 0);
        check("pre_lock_lost", bus.signal_lost, 1'b1);
        repeat (2) wave(500, 500);
        check("clean_period", bus.period_cnt_reg, 32'd1000);
        check("clean_freq", bus.freq_out, 32'd100000);
        check("clean_lost", bus.signal_lost, 1'b0);
        drain("clean");

        // Alternating 999 / 1001 averages to 1000.
        repeat (8) begin
            wave(500, 499);
            wave(500, 501);
        end
        check("alt_period", bus.period_cnt_reg, 32'd1000);
        drain("alt");

        // Short glitches on both levels must not create edges.
        repeat (8) glitch_wave(500, 500);
        check("glitch_period", bus.period_cnt_reg, 32'd1000);
        check("glitch_freq", bus.freq_out, 32'd100000);
        drain("glitch");

        // Input stops: timeout MAXP cycles after the last edge event.
        target = last_rise + DB + 3 + MAXP;
        while (cyc < target) @(negedge clk);
        check("lost_before_timeout", bus.signal_lost, 1'b0);
        @(negedge clk);
        check("lost_at_timeout", bus.signal_lost, 1'b1);
        model_clear();
        check("timeout_hold_period", bus.period_cnt_reg, 32'd1000);
        check("timeout_hold_freq", bus.freq_out, 32'd100000);
        repeat (20) @(negedge clk);
        drain("timeout");

        // Periods below MIN_PERIOD are discarded; 800 then locks.
        repeat (12) wave(150, 150);
        check("short_lost", bus.signal_lost, 1'b1);
        drain("short");
        repeat (9) wave(400, 400);
        check("p800_period", bus.period_cnt_reg, 32'd800);
        check("p800_freq", bus.freq_out, 32'd125000);
        check("p800_lost", bus.signal_lost, 1'b0);
        drain("p800");

        // Random periods and duty cycles, some below MIN_PERIOD.
        repeat (16) wave($urandom_range(700, 150), $urandom_range(700, 150));
        drain("random");

        // Reset mid-window loses the partial window.
        repeat (5) wave(500, 500);
        drain("pre_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("mid_reset");
        model_clear();
        rst = 1'b1;
        @(negedge clk);
        repeat (8) wave(500, 500);
        check("post_reset_early", obs_q.size(), 0);
        wave(500, 500);
        check("post_reset_period", bus.period_cnt_reg, 32'd1000);
        check("post_reset_freq", bus.freq_out, 32'd100000);
        check("post_reset_lost", bus.signal_lost, 1'b0);
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
